// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.

`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// Elaboration-time guard: the carry chain must split into whole segments.
`define ADDER_CHECK_DIV(W, S) \
  if (((W) % (S)) != 0) begin : g_bad_width \
    $error("pipelined_rca_adder: WIDTH must be a multiple of SEG"); \
  end

package adder_pkg;

  // Mode bit encodings for the sub input.
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Number of carry segments, which is also the stage count and the latency.
  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

`endif

// File: rtl/rca_segment.sv
// Combinational SEG-bit ripple-carry chain: {co, sum} = x + y + ci.

module rca_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           ci,
  output logic [SEG-1:0] sum,
  output logic           co
);

  logic [SEG:0] c;

  // Bit-serial full-adder chain inside the segment.
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[SEG];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor. Stage k resolves sum segment k
// using the carry registered by stage k-1; full-width operand and partial-sum
// vectors travel alongside, serving as the skew and deskew registers.

module pipelined_rca_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = nseg(WIDTH, SEG);
  localparam int LAST = NSEG - 1;

  `ADDER_CHECK_DIV(WIDTH, SEG)

  // Stage registers.
  logic [NSEG-1:0]  v_q;
  logic [NSEG-1:0]  c_q;
  logic [WIDTH-1:0] x_q [NSEG];
  logic [WIDTH-1:0] y_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic             ovf_q;

  // Values presented to each stage and the values it would capture.
  logic [NSEG-1:0]  v_in;
  logic [NSEG-1:0]  c_in;
  logic [NSEG-1:0]  seg_co;
  logic [WIDTH-1:0] x_in [NSEG];
  logic [WIDTH-1:0] y_in [NSEG];
  logic [WIDTH-1:0] s_in [NSEG];
  logic [WIDTH-1:0] s_nx [NSEG];
  logic [SEG-1:0]   seg_sum [NSEG];
  logic             ovf_nx;
  logic             stall;

  // The whole pipeline freezes only when a finished result is not taken.
  assign stall    = v_q[LAST] & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (k * SEG);

    if (k == 0) begin : g_first
      // Operand setup: subtraction is a + ~b + 1, so cin is overridden.
      assign v_in[k] = in_valid;
      assign x_in[k] = a;
      assign y_in[k] = (sub == SUB) ? ~b : b;
      assign c_in[k] = (sub == SUB) ? 1'b1 : cin;
      assign s_in[k] = '0;
    end else begin : g_rest
      assign v_in[k] = v_q[k-1];
      assign x_in[k] = x_q[k-1];
      assign y_in[k] = y_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
    end

    rca_segment #(
      .SEG (SEG)
    ) u_seg (
      .x   (x_in[k][k*SEG +: SEG]),
      .y   (y_in[k][k*SEG +: SEG]),
      .ci  (c_in[k]),
      .sum (seg_sum[k]),
      .co  (seg_co[k])
    );

    // Splice this stage's segment into the travelling partial sum.
    assign s_nx[k] = (s_in[k] & ~SEG_MASK) | (WIDTH'(seg_sum[k]) << (k * SEG));
  end

  // Signed overflow from the MSBs of a, b' and the completed sum.
  assign ovf_nx = (x_in[LAST][WIDTH-1] == y_in[LAST][WIDTH-1]) &&
                  (s_nx[LAST][WIDTH-1] != x_in[LAST][WIDTH-1]);

  // Advance every stage together unless the output is stalled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages see pre-edge values.
    if (rst) begin
      // NOTE: data registers are cleared too, since the final stage drives s/cout/ovf which must read zero after reset.
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q   <= v_in;
      c_q   <= seg_co;
      ovf_q <= ovf_nx;
      for (int k = 0; k < NSEG; k++) begin
        x_q[k] <= x_in[k];
        y_q[k] <= y_in[k];
        s_q[k] <= s_nx[k];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign s         = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed and stream checks for pipelined_rca_adder (16/4 main instance,
// plus 8/8 and 32/4 instances for the configuration sweep).

module tb_pipelined_rca_adder;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    int          t;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Main 16-bit, 4-stage instance.
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0, s;
  logic        cin = 1'b0, sub = 1'b0, cout, ovf;

  // 8-bit single-stage instance.
  logic        v8 = 1'b0, r8, ov8, or8 = 1'b1, c8 = 1'b0, sb8 = 1'b0, co8, of8;
  logic [7:0]  a8 = '0, b8 = '0, s8;

  // 32-bit, 8-stage instance.
  logic        v32 = 1'b0, r32, ov32, or32 = 1'b1, c32 = 1'b0, sb32 = 1'b0, co32, of32;
  logic [31:0] a32 = '0, b32 = '0, s32;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  pipelined_rca_adder #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  pipelined_rca_adder #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
    .a(a8), .b(b8), .cin(c8), .sub(sb8),
    .out_valid(ov8), .out_ready(or8), .s(s8), .cout(co8), .ovf(of8)
  );

  pipelined_rca_adder #(.WIDTH(32), .SEG(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32),
    .a(a32), .b(b32), .cin(c32), .sub(sb32),
    .out_valid(ov32), .out_ready(or32), .s(s32), .cout(co32), .ovf(of32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {ovf, cout, s} for a w-bit operation.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                            input logic ci, input logic sb);
    logic [63:0] mask, am, bm, full, sm;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'd0, ai} & mask;
    bm   = {32'd0, bi} & mask;
    if (!sb) begin
      full = am + bm + {63'd0, ci};
      sm   = full & mask;
      co   = full[w];
      ov   = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
    end else begin
      sm   = (am - bm) & mask;
      co   = (am >= bm);
      ov   = (am[w-1] != bm[w-1]) && (sm[w-1] != am[w-1]);
    end
    return {ov, co, sm[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one beat into the main instance and check its result and latency.
  task automatic send_and_check(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                                input logic ci, input logic sb,
                                input logic [15:0] es, input logic ec, input logic eo);
    int cnt;
    in_valid = 1'b1; a = ai; b = bi; cin = ci; sub = sb;
    tick();
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check({tag, ".latency"}, 64'(cnt), 64'd4);
    check({tag, ".s"},    64'(s),    64'(es));
    check({tag, ".cout"}, 64'(cout), 64'(ec));
    check({tag, ".ovf"},  64'(ovf),  64'(eo));
    tick();
  endtask

  initial begin
    beat_t       q16[$], q8[$], q32[$];
    beat_t       bt, ex;
    logic [33:0] r;
    logic        was_stall;
    logic [15:0] snap_s;
    logic        snap_c, snap_o;
    int          idx, got, cyc, n8, n32, got8, got32;

    // ---------------- reset state ----------------
    repeat (2) tick();
    rst = 1'b0;
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_ready",  64'(in_ready),  64'd1);
    check("reset.s",         64'(s),         64'd0);
    check("reset.cout",      64'(cout),      64'd0);
    check("reset.ovf",       64'(ovf),       64'd0);

    // ---------------- directed vectors ----------------
    send_and_check("wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_and_check("borrow",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_and_check("ovf_add",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_and_check("ovf_sub",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send_and_check("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    send_and_check("sub_ok",    16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    send_and_check("sub_equal", 16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // ---------------- back-pressure stream ----------------
    idx = 0; got = 0; cyc = 0; was_stall = 1'b0;
    snap_s = '0; snap_c = 1'b0; snap_o = 1'b0;
    while (got < 20 && cyc < 400) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (idx < 20) begin
        if (!in_valid) begin
          in_valid = 1'b1;
          a = 16'($urandom); b = 16'($urandom);
          cin = 1'($urandom); sub = 1'($urandom);
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check("stream.in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (was_stall) begin
        check("stall.out_valid", 64'(out_valid), 64'd1);
        check("stall.s",         64'(s),         64'(snap_s));
        check("stall.cout",      64'(cout),      64'(snap_c));
        check("stall.ovf",       64'(ovf),       64'(snap_o));
      end
      if (out_valid && out_ready) begin
        if (q16.size() == 0) begin
          check("stream.unexpected_result", 64'd1, 64'd0);
        end else begin
          ex = q16.pop_front();
          r  = ref_model(16, ex.a, ex.b, ex.cin, ex.sub);
          check("stream.s",    64'(s),    64'(r[15:0]));
          check("stream.cout", 64'(cout), 64'(r[32]));
          check("stream.ovf",  64'(ovf),  64'(r[33]));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        bt.a = {16'd0, a}; bt.b = {16'd0, b}; bt.cin = cin; bt.sub = sub; bt.t = cyc;
        q16.push_back(bt);
        idx++;
      end
      was_stall = out_valid && !out_ready;
      snap_s = s; snap_c = cout; snap_o = ovf;
      @(posedge clk);
      #1;
      if (in_valid && q16.size() > 0 && q16[$].t == cyc) in_valid = 1'b0;
      cyc++;
    end
    check("stream.results", 64'(got), 64'd20);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();

    // ---------------- reset mid-flight ----------------
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    tick();
    a = 16'h3333; b = 16'h0001;
    tick();
    a = 16'h5555; b = 16'h0002; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("midrst.in_ready", 64'(in_ready), 64'd1);
    check("midrst.s",        64'(s),        64'd0);
    for (int i = 0; i < 6; i++) begin
      check("midrst.out_valid", 64'(out_valid), 64'd0);
      tick();
    end
    send_and_check("post_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // ---------------- configuration sweep ----------------
    n8 = 0; n32 = 0; got8 = 0; got32 = 0; cyc = 0;
    while ((got8 < 40 || got32 < 40) && cyc < 300) begin
      v8  = (n8 < 40);
      v32 = (n32 < 40);
      if (n8 < 4) begin
        a8 = (n8 == 0) ? 8'hFF : (n8 == 1) ? 8'h7F : (n8 == 2) ? 8'h80 : 8'h00;
        b8 = (n8 == 3) ? 8'h01 : 8'h01;
        c8 = 1'b0; sb8 = (n8 >= 2);
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom); sb8 = 1'($urandom);
      end
      a32 = $urandom; b32 = $urandom; c32 = 1'($urandom); sb32 = 1'($urandom);
      if (n32 == 0) begin a32 = 32'hFFFF_FFFF; b32 = 32'h1; c32 = 1'b0; sb32 = 1'b0; end
      #1;
      if (ov8) begin
        if (q8.size() == 0) begin
          check("sweep8.unexpected_result", 64'd1, 64'd0);
        end else begin
          ex = q8.pop_front();
          r  = ref_model(8, ex.a, ex.b, ex.cin, ex.sub);
          check("sweep8.latency", 64'(cyc - ex.t), 64'd1);
          check("sweep8.s",    64'(s8),  64'(r[7:0]));
          check("sweep8.cout", 64'(co8), 64'(r[32]));
          check("sweep8.ovf",  64'(of8), 64'(r[33]));
        end
        got8++;
      end
      if (ov32) begin
        if (q32.size() == 0) begin
          check("sweep32.unexpected_result", 64'd1, 64'd0);
        end else begin
          ex = q32.pop_front();
          r  = ref_model(32, ex.a, ex.b, ex.cin, ex.sub);
          check("sweep32.latency", 64'(cyc - ex.t), 64'd8);
          check("sweep32.s",    64'(s32),  64'(r[31:0]));
          check("sweep32.cout", 64'(co32), 64'(r[32]));
          check("sweep32.ovf",  64'(of32), 64'(r[33]));
        end
        got32++;
      end
      if (v8 && r8) begin
        bt.a = {24'd0, a8}; bt.b = {24'd0, b8}; bt.cin = c8; bt.sub = sb8; bt.t = cyc;
        q8.push_back(bt);
        n8++;
      end
      if (v32 && r32) begin
        bt.a = a32; bt.b = b32; bt.cin = c32; bt.sub = sb32; bt.t = cyc;
        q32.push_back(bt);
        n32++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("sweep8.results",  64'(got8),  64'd40);
    check("sweep32.results", 64'(got32), 64'd40);
    v8 = 1'b0; v32 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
